// File: rtl/clk_rst_sequencer_if.sv
// Handshake bundle between the clock/reset sequencer and the SoC.
// The sequencer uses the slave view and the surrounding logic uses the master view.
interface clk_rst_sequencer_if;
   logic       locked;
   logic       sw_rst_req;
   logic       rst_periph;
   logic       rst_core;
   logic       ready;
   logic [2:0] state;
   logic [7:0] lock_loss_cnt;

   modport master (
      output locked,
      output sw_rst_req,
      input  rst_periph,
      input  rst_core,
      input  ready,
      input  state,
      input  lock_loss_cnt
   );

   modport slave (
      input  locked,
      input  sw_rst_req,
      output rst_periph,
      output rst_core,
      output ready,
      output state,
      output lock_loss_cnt
   );
endinterface

// File: rtl/clk_rst_sequencer.sv
// Staged reset sequencer behind the MMCM: releases peripherals, then the hart.
// Lock loss re-enters reset, software can reset the core alone, and lock losses are counted.
module clk_rst_sequencer #(
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned CORE_DELAY_CYCLES  = 16,
   parameter int unsigned CNT_W              = 16
) (
   input logic                 clk,
   input logic                 rst,
   clk_rst_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      RESET     = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      PERIPH_UP = 3'd3,
      RUN       = 3'd4,
      SW_RST    = 3'd5
   } state_e;

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_DELAY_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   locked_s;

   state_e                 state_q;
   state_e                 state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic [7:0]             llc_q;
   logic [7:0]             llc_d;
   logic                   rst_periph_q;
   logic                   rst_periph_d;
   logic                   rst_core_q;
   logic                   rst_core_d;
   logic                   ready_q;
   logic                   ready_d;

   // locked comes from another clock domain; only the last stage is trusted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.locked};
      end
   end

   assign locked_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      llc_d   = llc_q;
      case (state_q)
         RESET: begin
            state_d = WAIT_LOCK;
            cnt_d   = CNT_ZERO;
         end
         WAIT_LOCK: begin
            cnt_d = CNT_ZERO;
            if (locked_s) begin
               state_d = STABLE;
            end
         end
         STABLE: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = PERIPH_UP;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PERIPH_UP, SW_RST: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = CNT_ZERO;
               if (llc_q != 8'hFF) begin
                  llc_d = llc_q + 8'd1;
               end
            end else if (cnt_q == CORE_LAST) begin
               state_d = RUN;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         RUN: begin
            cnt_d = CNT_ZERO;
            // lock loss wins over a coincident software request
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               if (llc_q != 8'hFF) begin
                  llc_d = llc_q + 8'd1;
               end
            end else if (bus.sw_rst_req) begin
               state_d = SW_RST;
            end
         end
         default: begin
            state_d = RESET;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // outputs are decoded from the next state so they flip on the same edge
   always_comb begin
      rst_periph_d = 1'b1;
      rst_core_d   = 1'b1;
      ready_d      = 1'b0;
      case (state_d)
         PERIPH_UP, SW_RST: begin
            rst_periph_d = 1'b0;
         end
         RUN: begin
            rst_periph_d = 1'b0;
            rst_core_d   = 1'b0;
            ready_d      = 1'b1;
         end
         default: begin
            rst_periph_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RESET;
         cnt_q        <= '0;
         llc_q        <= '0;
         rst_periph_q <= 1'b1;
         rst_core_q   <= 1'b1;
         ready_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         llc_q        <= llc_d;
         rst_periph_q <= rst_periph_d;
         rst_core_q   <= rst_core_d;
         ready_q      <= ready_d;
      end
   end

   assign bus.rst_periph    = rst_periph_q;
   assign bus.rst_core      = rst_core_q;
   assign bus.ready         = ready_q;
   assign bus.state         = state_q;
   assign bus.lock_loss_cnt = llc_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer with short delay parameters.
// Edge 1 is the first rising clock edge after rst falls.
module tb_clk_rst_sequencer;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   edge_n;

   clk_rst_sequencer_if bus ();

   clk_rst_sequencer #(
      .SYNC_STAGES        (2),
      .LOCK_STABLE_CYCLES (8),
      .CORE_DELAY_CYCLES  (4),
      .CNT_W              (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic tick_to(input int e);
      while (edge_n < e) tick();
   endtask

   task automatic wait_state(input logic [2:0] s, input int lim,
                             input string tag);
      int n;
      n = 0;
      while (bus.state !== s && n < lim) begin
         tick();
         n++;
      end
      chk(tag, {5'd0, bus.state}, {5'd0, s});
   endtask

   task automatic do_reset(input logic lk);
      rst        = 1'b1;
      bus.locked = lk;
      bus.sw_rst_req = 1'b0;
      repeat (3) @(negedge clk);
      rst    = 1'b0;
      edge_n = 0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      edge_n = 0;
      rst = 1'b1;
      bus.locked = 1'b1;
      bus.sw_rst_req = 1'b0;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_state", {5'd0, bus.state}, 8'd0);
      chk("rst_periph", {7'd0, bus.rst_periph}, 8'd1);
      chk("rst_core", {7'd0, bus.rst_core}, 8'd1);
      chk("rst_ready", {7'd0, bus.ready}, 8'd0);
      chk("rst_llc", bus.lock_loss_cnt, 8'd0);

      // power-up with locked high
      do_reset(1'b1);
      tick_to(1);
      chk("pu_e1_state", {5'd0, bus.state}, 8'd1);
      tick_to(2);
      chk("pu_e2_state", {5'd0, bus.state}, 8'd1);
      tick_to(3);
      chk("pu_e3_state", {5'd0, bus.state}, 8'd2);
      tick_to(10);
      chk("pu_e10_state", {5'd0, bus.state}, 8'd2);
      chk("pu_e10_periph", {7'd0, bus.rst_periph}, 8'd1);
      tick_to(11);
      chk("pu_e11_state", {5'd0, bus.state}, 8'd3);
      chk("pu_e11_periph", {7'd0, bus.rst_periph}, 8'd0);
      chk("pu_e11_core", {7'd0, bus.rst_core}, 8'd1);
      tick_to(14);
      chk("pu_e14_ready", {7'd0, bus.ready}, 8'd0);
      tick_to(15);
      chk("pu_e15_state", {5'd0, bus.state}, 8'd4);
      chk("pu_e15_core", {7'd0, bus.rst_core}, 8'd0);
      chk("pu_e15_ready", {7'd0, bus.ready}, 8'd1);
      chk("pu_e15_llc", bus.lock_loss_cnt, 8'd0);

      // lock loss in RUN
      tick_to(20);
      bus.locked = 1'b0;
      tick_to(22);
      chk("ll_e22_ready", {7'd0, bus.ready}, 8'd1);
      tick_to(23);
      chk("ll_e23_state", {5'd0, bus.state}, 8'd1);
      chk("ll_e23_periph", {7'd0, bus.rst_periph}, 8'd1);
      chk("ll_e23_core", {7'd0, bus.rst_core}, 8'd1);
      chk("ll_e23_ready", {7'd0, bus.ready}, 8'd0);
      chk("ll_e23_llc", bus.lock_loss_cnt, 8'd1);
      bus.locked = 1'b1;
      tick_to(25);
      chk("ll_e25_state", {5'd0, bus.state}, 8'd1);
      tick_to(26);
      chk("ll_e26_state", {5'd0, bus.state}, 8'd2);
      tick_to(33);
      chk("ll_e33_state", {5'd0, bus.state}, 8'd2);
      tick_to(34);
      chk("ll_e34_state", {5'd0, bus.state}, 8'd3);
      tick_to(37);
      chk("ll_e37_state", {5'd0, bus.state}, 8'd3);
      tick_to(38);
      chk("ll_e38_state", {5'd0, bus.state}, 8'd4);
      chk("ll_e38_ready", {7'd0, bus.ready}, 8'd1);

      // software core reset, second pulse ignored
      tick_to(40);
      bus.sw_rst_req = 1'b1;
      tick_to(41);
      bus.sw_rst_req = 1'b0;
      chk("sw_e41_state", {5'd0, bus.state}, 8'd5);
      chk("sw_e41_core", {7'd0, bus.rst_core}, 8'd1);
      chk("sw_e41_periph", {7'd0, bus.rst_periph}, 8'd0);
      chk("sw_e41_ready", {7'd0, bus.ready}, 8'd0);
      tick_to(42);
      bus.sw_rst_req = 1'b1;
      tick_to(43);
      bus.sw_rst_req = 1'b0;
      chk("sw_e43_state", {5'd0, bus.state}, 8'd5);
      tick_to(44);
      chk("sw_e44_state", {5'd0, bus.state}, 8'd5);
      tick_to(45);
      chk("sw_e45_state", {5'd0, bus.state}, 8'd4);
      chk("sw_e45_core", {7'd0, bus.rst_core}, 8'd0);
      tick_to(46);
      chk("sw_e46_state", {5'd0, bus.state}, 8'd4);

      // sw request and first low locked_s in the same cycle
      tick_to(50);
      bus.locked = 1'b0;
      tick_to(52);
      chk("sim_e52_state", {5'd0, bus.state}, 8'd4);
      bus.sw_rst_req = 1'b1;
      tick_to(53);
      bus.sw_rst_req = 1'b0;
      chk("sim_e53_state", {5'd0, bus.state}, 8'd1);
      chk("sim_e53_llc", bus.lock_loss_cnt, 8'd2);

      // lock glitch while in STABLE
      do_reset(1'b1);
      tick_to(6);
      bus.locked = 1'b0;
      tick_to(8);
      chk("gl_e8_state", {5'd0, bus.state}, 8'd2);
      tick_to(9);
      bus.locked = 1'b1;
      chk("gl_e9_state", {5'd0, bus.state}, 8'd1);
      chk("gl_e9_periph", {7'd0, bus.rst_periph}, 8'd1);
      tick_to(11);
      chk("gl_e11_state", {5'd0, bus.state}, 8'd1);
      tick_to(12);
      chk("gl_e12_state", {5'd0, bus.state}, 8'd2);
      tick_to(19);
      chk("gl_e19_state", {5'd0, bus.state}, 8'd2);
      chk("gl_e19_periph", {7'd0, bus.rst_periph}, 8'd1);
      tick_to(20);
      chk("gl_e20_state", {5'd0, bus.state}, 8'd3);
      chk("gl_e20_periph", {7'd0, bus.rst_periph}, 8'd0);
      chk("gl_e20_llc", bus.lock_loss_cnt, 8'd0);

      // 260 lock losses in PERIPH_UP
      for (int i = 0; i < 260; i++) begin
         bus.locked = 1'b1;
         wait_state(3'd3, 40, "sat_to_periph");
         bus.locked = 1'b0;
         wait_state(3'd1, 10, "sat_to_wait");
         if (i == 199) chk("sat_llc_200", bus.lock_loss_cnt, 8'd200);
      end
      chk("sat_llc_255", bus.lock_loss_cnt, 8'd255);

      // async reset mid-PERIPH_UP, checked before any clock edge
      bus.locked = 1'b1;
      wait_state(3'd3, 40, "ar_to_periph");
      #2;
      rst = 1'b1;
      #1;
      chk("ar_state", {5'd0, bus.state}, 8'd0);
      chk("ar_periph", {7'd0, bus.rst_periph}, 8'd1);
      chk("ar_core", {7'd0, bus.rst_core}, 8'd1);
      chk("ar_ready", {7'd0, bus.ready}, 8'd0);
      chk("ar_llc", bus.lock_loss_cnt, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      edge_n = 0;
      tick_to(1);
      chk("ar_e1_state", {5'd0, bus.state}, 8'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
